// File: rtl/vga_timing_gen.sv
// VGA raster timing generator.
// Runs on the system clock and emits a one-cycle pixel enable every CLK_DIV
// clocks. Line order from count 0 is sync, back porch, active, front porch,
// and the vertical axis uses the same order. Every output is registered and
// decoded from the next-state counter values, so it describes the hcount and
// vcount that are visible in the same cycle.
module vga_timing_gen #(
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int HSYNC_POL = 1,
    parameter int VSYNC_POL = 1,
    parameter int CLK_DIV   = 4,
    parameter int CNT_W     = 10,
    parameter int FRAME_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    output logic               pix_ce,
    output logic [CNT_W-1:0]   hcount,
    output logic [CNT_W-1:0]   vcount,
    output logic               hsync,
    output logic               vsync,
    output logic               active,
    output logic [CNT_W-1:0]   x,
    output logic [CNT_W-1:0]   y,
    output logic               line_start,
    output logic               frame_start,
    output logic [FRAME_W-1:0] frame_cnt
);

    localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int HA0     = H_SYNC + H_BP;
    localparam int VA0     = V_SYNC + V_BP;

    // A one-bit divider is kept even for CLK_DIV=1; it simply stays at 0.
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_SYNC_END = CNT_W'(H_SYNC);
    localparam logic [CNT_W-1:0] V_SYNC_END = CNT_W'(V_SYNC);
    localparam logic [CNT_W-1:0] H_ACT_LO   = CNT_W'(HA0);
    localparam logic [CNT_W-1:0] H_ACT_HI   = CNT_W'(HA0 + H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT_LO   = CNT_W'(VA0);
    localparam logic [CNT_W-1:0] V_ACT_HI   = CNT_W'(VA0 + V_ACTIVE);

    localparam logic HS_ON = 1'(HSYNC_POL);
    localparam logic VS_ON = 1'(VSYNC_POL);

    // Divider, raster and frame state.
    logic [DIV_W-1:0]   div_reg,       div_next;
    logic [CNT_W-1:0]   hcount_reg,    hcount_next;
    logic [CNT_W-1:0]   vcount_reg,    vcount_next;
    logic [FRAME_W-1:0] frame_cnt_reg, frame_cnt_next;

    // Registered decodes of the next raster position.
    logic               pix_ce_reg;
    logic               hsync_reg,       hsync_next;
    logic               vsync_reg,       vsync_next;
    logic               active_reg,      active_next;
    logic [CNT_W-1:0]   x_reg,           x_next;
    logic [CNT_W-1:0]   y_reg,           y_next;
    logic               line_start_reg,  line_start_next;
    logic               frame_start_reg, frame_start_next;

    logic               ce_now;
    logic               h_in_window;
    logic               v_in_window;

    // Next-state logic: divider wrap, raster advance, and output decode.
    always_comb begin
        ce_now           = (div_reg == DIV_LAST);
        div_next         = ce_now ? '0 : div_reg + 1'b1;
        hcount_next      = hcount_reg;
        vcount_next      = vcount_reg;
        frame_cnt_next   = frame_cnt_reg;
        line_start_next  = 1'b0;
        frame_start_next = 1'b0;

        if (ce_now) begin
            if (hcount_reg == H_LAST) begin
                // hcount and vcount wrap on the same enable, so a frame
                // always ends exactly on a line boundary.
                hcount_next     = '0;
                line_start_next = 1'b1;
                if (vcount_reg == V_LAST) begin
                    vcount_next      = '0;
                    frame_start_next = 1'b1;
                    frame_cnt_next   = frame_cnt_reg + 1'b1;
                end else begin
                    vcount_next = vcount_reg + 1'b1;
                end
            end else begin
                hcount_next = hcount_reg + 1'b1;
            end
        end

        h_in_window = (hcount_next >= H_ACT_LO) && (hcount_next < H_ACT_HI);
        v_in_window = (vcount_next >= V_ACT_LO) && (vcount_next < V_ACT_HI);
        active_next = h_in_window && v_in_window;
        x_next      = active_next ? (hcount_next - H_ACT_LO) : '0;
        y_next      = active_next ? (vcount_next - V_ACT_LO) : '0;
        hsync_next  = (hcount_next < H_SYNC_END) ? HS_ON : ~HS_ON;
        vsync_next  = (vcount_next < V_SYNC_END) ? VS_ON : ~VS_ON;
    end

    // State and output registers. Reset places the raster at (0,0) with the syncs asserted.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_reg         <= '0;
            hcount_reg      <= '0;
            vcount_reg      <= '0;
            frame_cnt_reg   <= '0;
            pix_ce_reg      <= 1'b0;
            hsync_reg       <= HS_ON;
            vsync_reg       <= VS_ON;
            active_reg      <= 1'b0;
            x_reg           <= '0;
            y_reg           <= '0;
            line_start_reg  <= 1'b0;
            frame_start_reg <= 1'b0;
        end else begin
            div_reg         <= div_next;
            hcount_reg      <= hcount_next;
            vcount_reg      <= vcount_next;
            frame_cnt_reg   <= frame_cnt_next;
            pix_ce_reg      <= ce_now;
            hsync_reg       <= hsync_next;
            vsync_reg       <= vsync_next;
            active_reg      <= active_next;
            x_reg           <= x_next;
            y_reg           <= y_next;
            line_start_reg  <= line_start_next;
            frame_start_reg <= frame_start_next;
        end
    end

    assign pix_ce      = pix_ce_reg;
    assign hcount      = hcount_reg;
    assign vcount      = vcount_reg;
    assign hsync       = hsync_reg;
    assign vsync       = vsync_reg;
    assign active      = active_reg;
    assign x           = x_reg;
    assign y           = y_reg;
    assign line_start  = line_start_reg;
    assign frame_start = frame_start_reg;
    assign frame_cnt   = frame_cnt_reg;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen.
// There are three instances. A uses a small raster of 15x8 with CLK_DIV=4,
// FRAME_W=2 and active-high syncs. B uses the same raster with CLK_DIV=1 and
// active-low syncs. C uses the default 640x480 timing and is only checked
// near the start of a line. The expected values come from closed-form raster
// arithmetic on k, the number of clocks since reset was released, and from
// hand-computed constants.
module tb_vga_timing_gen;

    // Raster geometry of the small instances.
    localparam int HS = 3, HB = 2, HA = 8, HF = 2;
    localparam int VS = 2, VB = 1, VA = 4, VF = 1;
    localparam int HT = HS + HB + HA + HF;   // 15
    localparam int VT = VS + VB + VA + VF;   // 8
    localparam int HA0 = HS + HB;            // 5
    localparam int VA0 = VS + VB;            // 3

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int k = 0;
    bit chk_on = 1'b0;
    int ph = 0;
    int a_fs_cnt = 0, a_ls_cnt = 0, b_fs_cnt = 0, a_fs2 = 0;
    logic [1:0] fc_q[$];

    // Instance A outputs.
    logic a_pix_ce, a_hsync, a_vsync, a_active, a_line_start, a_frame_start;
    logic [4:0] a_hcount, a_vcount, a_x, a_y;
    logic [1:0] a_frame_cnt;
    // Instance B outputs.
    logic b_pix_ce, b_hsync, b_vsync, b_active, b_line_start, b_frame_start;
    logic [4:0] b_hcount, b_vcount, b_x, b_y;
    logic [1:0] b_frame_cnt;
    // Instance C outputs.
    logic c_pix_ce, c_hsync, c_vsync, c_active, c_line_start, c_frame_start;
    logic [9:0] c_hcount, c_vcount, c_x, c_y;
    logic [7:0] c_frame_cnt;

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HSYNC_POL(1), .VSYNC_POL(1), .CLK_DIV(4), .CNT_W(5), .FRAME_W(2)
    ) dut_a (
        .clk(clk), .rst(rst), .pix_ce(a_pix_ce), .hcount(a_hcount), .vcount(a_vcount),
        .hsync(a_hsync), .vsync(a_vsync), .active(a_active), .x(a_x), .y(a_y),
        .line_start(a_line_start), .frame_start(a_frame_start), .frame_cnt(a_frame_cnt)
    );

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HSYNC_POL(0), .VSYNC_POL(0), .CLK_DIV(1), .CNT_W(5), .FRAME_W(2)
    ) dut_b (
        .clk(clk), .rst(rst), .pix_ce(b_pix_ce), .hcount(b_hcount), .vcount(b_vcount),
        .hsync(b_hsync), .vsync(b_vsync), .active(b_active), .x(b_x), .y(b_y),
        .line_start(b_line_start), .frame_start(b_frame_start), .frame_cnt(b_frame_cnt)
    );

    vga_timing_gen dut_c (
        .clk(clk), .rst(rst), .pix_ce(c_pix_ce), .hcount(c_hcount), .vcount(c_vcount),
        .hsync(c_hsync), .vsync(c_vsync), .active(c_active), .x(c_x), .y(c_y),
        .line_start(c_line_start), .frame_start(c_frame_start), .frame_cnt(c_frame_cnt)
    );

    // Bundle layout: [27]pix_ce [26]line_start [25]frame_start [24]active
    // [23]hsync [22]vsync [21:17]h [16:12]v [11:7]x [6:2]y [1:0]frame_cnt
    logic [31:0] a_bus, b_bus;
    assign a_bus = {4'd0, a_pix_ce, a_line_start, a_frame_start, a_active, a_hsync, a_vsync,
                    a_hcount, a_vcount, a_x, a_y, a_frame_cnt};
    assign b_bus = {4'd0, b_pix_ce, b_line_start, b_frame_start, b_active, b_hsync, b_vsync,
                    b_hcount, b_vcount, b_x, b_y, b_frame_cnt};

    // Clocks since the last reset edge; 0 while reset is held.
    always @(posedge clk) begin
        if (rst) k <= 0;
        else     k <= k + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (k=%0d)", tag, got, exp, k);
        end
    endtask

    // Expected small-raster bundle kk clocks after reset for divider d and sync polarity pol.
    function automatic logic [31:0] raster(input int kk, input int d, input bit pol);
        int p, h, v, f;
        bit ce, act;
        p   = kk / d;
        ce  = (kk > 0) && (kk % d == 0);
        h   = p % HT;
        v   = (p / HT) % VT;
        f   = (p / (HT * VT)) % 4;
        act = (h >= HA0) && (h < HA0 + HA) && (v >= VA0) && (v < VA0 + VA);
        raster = {4'd0, ce, ce && (h == 0), ce && (h == 0) && (v == 0), act,
                  (h < HS) ? pol : ~pol, (v < VS) ? pol : ~pol,
                  5'(h), 5'(v), act ? 5'(h - HA0) : 5'd0, act ? 5'(v - VA0) : 5'd0, 2'(f)};
    endfunction

    // Per-clock checks, sampled on the falling edge.
    always @(negedge clk) begin
        if (chk_on) begin
            check("a_raster", a_bus, raster(k, 4, 1'b1));
            check("b_raster", b_bus, raster(k, 1, 1'b0));
            if (k == 3)   check("a_h_before_step", a_hcount, 0);
            if (k == 4)   check("a_h_first_step", a_hcount, 1);
            if (k == 200) check("a_first_active", {a_active, a_x, a_y}, {1'b1, 5'd0, 5'd0});
            if (k == 408) check("a_last_active", {a_active, a_x, a_y}, {1'b1, 5'd7, 5'd3});
            if (k == 412) check("a_after_h_window", {a_active, a_x, a_y}, 11'd0);
            if (k == 440) check("a_below_v_window", {a_active, a_x, a_y}, 11'd0);
            if (k == 479) check("a_no_early_fs", {a_frame_start, a_frame_cnt}, 3'b0_00);
            if (k == 480) check("a_first_fs", {a_frame_start, a_hcount, a_vcount, a_frame_cnt},
                                {1'b1, 5'd0, 5'd0, 2'd1});
            if (k == 2)   check("b_hsync_low", b_hsync, 0);
            if (k == 3)   check("b_hsync_high", b_hsync, 1);
            if (k == 120) check("b_first_fs", {b_frame_start, b_frame_cnt}, 3'b1_01);
            if (k == 240) check("b_second_fs", {b_frame_start, b_frame_cnt}, 3'b1_10);
            if (k == 3)   check("c_h_before_step", {c_pix_ce, c_hcount}, 11'd0);
            if (k == 4)   check("c_h_first_step", {c_pix_ce, c_hcount}, {1'b1, 10'd1});
            if (k == 5)   check("c_ce_low", c_pix_ce, 0);
            if (k == 8)   check("c_ce_period", {c_pix_ce, c_hcount}, {1'b1, 10'd2});
            if (k == 380) check("c_hsync_h95", {c_hsync, c_hcount}, {1'b1, 10'd95});
            if (k == 384) check("c_hsync_h96", {c_hsync, c_hcount}, {1'b0, 10'd96});
            if (k == 384) check("c_vsync_v0", {c_vsync, c_vcount, c_active}, {1'b1, 10'd0, 1'b0});

            if (a_frame_start) begin
                $display("A frame_start at k=%0d frame_cnt=%0d", k, a_frame_cnt);
                if (ph == 1) begin
                    a_fs_cnt++;
                    fc_q.push_back(a_frame_cnt);
                end
                if (ph == 3) a_fs2++;
            end
            if (ph == 1 && a_line_start)  a_ls_cnt++;
            if (ph == 1 && b_frame_start) b_fs_cnt++;
        end
    end

    logic [1:0] exp_fc [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 chk_on = 1'b1;
        @(negedge clk) rst = 1'b0;
        ph = 1;

        // Five small-raster frames (480 clks each) plus a few clocks.
        repeat (2410) @(posedge clk);
        #2;
        check("a_fs_count", a_fs_cnt, 5);
        check("a_ls_count", a_ls_cnt, 40);
        check("b_fs_count", b_fs_cnt, 20);
        check("a_fc_len", fc_q.size(), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < fc_q.size()) check("a_fc_seq", fc_q[i], exp_fc[i]);
            else                 check("a_fc_seq", 32'hFFFF_FFFF, exp_fc[i]);
        end
        ph = 2;

        // Advance to (h,v)=(10,4) in frame 6, then reset for one cycle.
        repeat (272) @(posedge clk);
        #1 check("a_pre_rst_pos", {a_hcount, a_vcount}, {5'd10, 5'd4});
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1 check("a_mid_rst", a_bus, 32'h00C0_0000);
        check("b_mid_rst", b_bus, 32'h0000_0000);
        @(negedge clk) rst = 1'b0;
        ph = 3;

        // Exactly one frame_start once a full frame completes after the reset.
        repeat (481) @(posedge clk);
        #2;
        check("a_fs_after_rst", a_fs2, 1);
        check("a_fc_after_rst", a_frame_cnt, 1);

        repeat (10) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
